mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_pkg.sv | 6 +
 rtl/mem_bus_watchdog.sv | 19 +
 rtl/mem_access_unit.sv | 81 ++++++++
 tb/tb_mem_access_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM state type, abort data and watchdog counter width for mem_access_unit
package mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_state_t;
  localparam logic [31:0] MEM_ABORT_DATA = 32'hDEADBEEF;
  localparam int MEM_CNT_W = 8;
endpackage

// File: rtl/mem_bus_watchdog.sv
// mem_bus_watchdog: counts enabled cycles; expired marks the TIMEOUT_CYCLES-th enabled cycle
module mem_bus_watchdog
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [MEM_CNT_W-1:0] r_count;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_count <= '0;
    else if (clear) r_count <= '0;
    else if (enable) r_count <= r_count + MEM_CNT_W'(1);
  assign expired = enable && (r_count == MEM_CNT_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data bus master with stall, timeout abort and optional alignment check.
// Define MEM_ALIGN_CHECK_EN to reject misaligned accesses in IDLE via misalign_err.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        bus_err,
  output logic        misalign_err
);
  mem_state_t r_state, w_next;
  logic r_we, r_bus_err;
  logic [31:0] r_addr, r_wdata, r_read_data;
  logic w_access, w_misalign, w_start, w_in_wait, w_ack, w_expired, w_timeout;
  assign w_access = mem_read | mem_write;
`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = (r_state == IDLE) && w_access && (addr[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif
  assign w_start   = (r_state == IDLE) && w_access && !w_misalign;
  assign w_in_wait = (r_state == WAIT);
  assign w_ack     = w_in_wait && bus_ack;
  assign w_timeout = w_expired && !bus_ack;
  mem_bus_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (!w_in_wait),
    .enable (w_in_wait),
    .expired(w_expired)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  // DONE always returns to IDLE so inputs still held by the same instruction are not reissued
  always_comb begin
    w_next       = r_state;
    stall        = 1'b0;
    misalign_err = 1'b0;
    w_next       = w_start ? WAIT : (w_ack || w_timeout) ? DONE : (r_state == DONE) ? IDLE : r_state;
    stall        = !reset && (w_start || (w_in_wait && !bus_ack));
    misalign_err = !reset && w_misalign;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_read_data <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      if (w_start) begin
        r_we    <= mem_write;
        r_addr  <= addr & 32'hFFFF_FFFC;
        r_wdata <= write_data;
      end
      r_bus_err <= w_timeout;
      if (!r_we && w_ack) r_read_data <= bus_rdata;
      else if (!r_we && w_timeout) r_read_data <= MEM_ABORT_DATA;
    end
  assign bus_req   = w_in_wait;
  assign bus_we    = r_we;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;
  assign read_data = r_read_data;
  assign bus_err   = r_bus_err;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit (TIMEOUT_CYCLES=4 and =2 instances)
module tb_mem_access_unit;
  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;
  logic clk = 1'b0;
  logic reset, mem_read, mem_write, bus_ack, sel;
  logic [31:0] addr, write_data, bus_rdata;
  logic a_req, a_we, a_stall, a_err, a_mis, b_req, b_we, b_stall, b_err, b_mis;
  logic [31:0] a_addr, a_wdata, a_rd, b_addr, b_wdata, b_rd;
  logic m_req, m_we, m_stall, m_err, m_mis;
  logic [31:0] m_addr, m_wdata, m_rd, model_rd;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write), .addr(addr),
    .write_data(write_data), .bus_req(a_req), .bus_we(a_we), .bus_addr(a_addr),
    .bus_wdata(a_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .read_data(a_rd),
    .stall(a_stall), .bus_err(a_err), .misalign_err(a_mis)
  );
  mem_access_unit #(.TIMEOUT_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write), .addr(addr),
    .write_data(write_data), .bus_req(b_req), .bus_we(b_we), .bus_addr(b_addr),
    .bus_wdata(b_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .read_data(b_rd),
    .stall(b_stall), .bus_err(b_err), .misalign_err(b_mis)
  );
  assign m_req   = sel ? b_req : a_req;
  assign m_we    = sel ? b_we : a_we;
  assign m_stall = sel ? b_stall : a_stall;
  assign m_err   = sel ? b_err : a_err;
  assign m_mis   = sel ? b_mis : a_mis;
  assign m_addr  = sel ? b_addr : a_addr;
  assign m_wdata = sel ? b_wdata : a_wdata;
  assign m_rd    = sel ? b_rd : a_rd;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0;
    addr = '0; write_data = '0; bus_rdata = '0;
    @(negedge clk);
    reset = 1'b0;
    model_rd = '0;
  endtask

  // ack_at: WAIT cycle (1-based) carrying bus_ack, 0 for none
  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input int ack_at, input logic [31:0] rdata, input int exp_cycles);
    int n, k;
    logic done;
    logic [31:0] ea;
    exp_t e;
    ea = a & 32'hFFFF_FFFC;
    @(negedge clk);
    mem_read = rd; mem_write = wr; addr = a; write_data = d; bus_ack = 1'b0;
    #1;
    checks++; if (m_stall !== 1'b1) begin failures++; $display("FAIL issue_stall got=%0b exp=1", m_stall); end
    checks++; if (m_mis !== 1'b0) begin failures++; $display("FAIL issue_misalign got=%0b exp=0", m_mis); end
    if (wr) begin e.rd = model_rd; e.err = 1'b0; end
    else if (ack_at > 0) begin e.rd = rdata; e.err = 1'b0; end
    else begin e.rd = 32'hDEADBEEF; e.err = 1'b1; end
    model_rd = e.rd;
    sb.push_back(e);
    n = 1; k = 0; done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (m_req) begin
        k++; n++;
        checks++; if (m_addr !== ea || m_we !== wr) begin failures++; $display("FAIL bus_latch got addr=%h we=%0b exp addr=%h we=%0b", m_addr, m_we, ea, wr); end
        if (wr) begin
          checks++; if (m_wdata !== d) begin failures++; $display("FAIL bus_wdata got=%h exp=%h", m_wdata, d); end
        end
        bus_ack = (k == ack_at);
        bus_rdata = bus_ack ? rdata : $urandom;
        #1;
        checks++; if (m_stall !== !bus_ack) begin failures++; $display("FAIL wait_stall got=%0b exp=%0b cycle=%0d", m_stall, !bus_ack, k); end
      end else begin
        done = 1'b1;
        bus_ack = 1'b0;
        e = sb.pop_front();
        checks++; if (m_stall !== 1'b0) begin failures++; $display("FAIL done_stall got=%0b exp=0", m_stall); end
        checks++; if (m_rd !== e.rd) begin failures++; $display("FAIL read_data got=%h exp=%h", m_rd, e.rd); end
        checks++; if (m_err !== e.err) begin failures++; $display("FAIL bus_err got=%0b exp=%0b", m_err, e.err); end
      end
    end
    if (!done) begin checks++; failures++; $display("FAIL done_bound got=none exp=DONE"); end
    checks++; if (n !== exp_cycles) begin failures++; $display("FAIL access_cycles got=%0d exp=%0d", n, exp_cycles); end
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    #1;
    checks++; if (m_err !== 1'b0 || m_stall !== 1'b0 || m_req !== 1'b0) begin failures++; $display("FAIL idle_after got err=%0b stall=%0b req=%0b exp=0", m_err, m_stall, m_req); end
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_read = 1'b1; mem_write = 1'b0; bus_ack = 1'b0;
    addr = 32'h104; write_data = 32'h1; bus_rdata = '0;
    @(negedge clk); #1;
    checks++; if ({a_req, a_we, a_stall, a_err, a_mis} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {a_req, a_we, a_stall, a_err, a_mis}); end
    checks++; if (a_addr !== 0 || a_wdata !== 0 || a_rd !== 0) begin failures++; $display("FAIL reset_data got addr=%h wdata=%h rd=%h exp=0", a_addr, a_wdata, a_rd); end
    mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_rd = '0;
  endtask

  task automatic test_load();
    access(1'b1, 1'b0, 32'h100, 32'h0, 3, 32'hCAFEF00D, 4);
  endtask

  task automatic test_store();
    access(1'b0, 1'b1, 32'h20, 32'h12345678, 1, 32'h0, 2);
  endtask

  task automatic test_timeout();
    access(1'b1, 1'b0, 32'h40, 32'h0, 0, 32'h0, 5);
  endtask

  task automatic test_both_high();
    access(1'b1, 1'b1, 32'h80, 32'hA5A50F0F, 2, 32'h11111111, 3);
  endtask

  task automatic test_ack_outside();
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'h77777777;
    @(negedge clk); #1;
    checks++; if (a_rd !== model_rd || a_req !== 1'b0 || a_stall !== 1'b0) begin failures++; $display("FAIL ack_outside got rd=%h req=%0b stall=%0b exp rd=%h", a_rd, a_req, a_stall, model_rd); end
    bus_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    access(1'b1, 1'b0, 32'h200, 32'h0, 1, 32'h00000001, 2);
    access(1'b1, 1'b0, 32'h204, 32'h0, 2, 32'h89ABCDEF, 3);
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    mem_read = 1'b1; addr = 32'h400;
    @(negedge clk);
    @(negedge clk);
    checks++; if (a_req !== 1'b1) begin failures++; $display("FAIL rst_wait_req got=%0b exp=1", a_req); end
    reset = 1'b1;
    #1;
    checks++; if (a_req !== 1'b0 || a_stall !== 1'b0 || a_rd !== 0 || a_addr !== 0) begin failures++; $display("FAIL rst_wait_clear got req=%0b stall=%0b rd=%h addr=%h exp=0", a_req, a_stall, a_rd, a_addr); end
    mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h0BAD0BAD;
    #1;
    checks++; if (a_req !== 1'b0 || a_stall !== 1'b0) begin failures++; $display("FAIL late_ack_idle got req=%0b stall=%0b exp=0", a_req, a_stall); end
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    checks++; if (a_rd !== 0 || a_err !== 1'b0 || a_req !== 1'b0) begin failures++; $display("FAIL late_ack_ignored got rd=%h err=%0b req=%0b exp=0", a_rd, a_err, a_req); end
    model_rd = '0;
  endtask

  task automatic test_misalign();
`ifdef MEM_ALIGN_CHECK_EN
    @(negedge clk);
    mem_read = 1'b1; addr = 32'h102;
    #1;
    checks++; if (a_mis !== 1'b1 || a_stall !== 1'b0) begin failures++; $display("FAIL misalign_flag got mis=%0b stall=%0b exp mis=1 stall=0", a_mis, a_stall); end
    @(negedge clk);
    checks++; if (a_req !== 1'b0 || a_rd !== model_rd) begin failures++; $display("FAIL misalign_nobus got req=%0b rd=%h exp req=0 rd=%h", a_req, a_rd, model_rd); end
    mem_read = 1'b0;
`else
    access(1'b1, 1'b0, 32'h102, 32'h0, 1, 32'hFEED0001, 2);
`endif
  endtask

  task automatic test_coincide();
    do_reset();
    sel = 1'b1;
    access(1'b1, 1'b0, 32'h300, 32'h0, 2, 32'h5A5A1234, 3);
    sel = 1'b0;
  endtask

  initial begin
    sel = 1'b0;
    test_reset();
    test_load();
    test_store();
    test_timeout();
    test_both_high();
    test_ack_outside();
    test_back_to_back();
    test_reset_in_wait();
    test_misalign();
    test_coincide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
